// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron output stage: Q-format, widths,
// activation select codes and serialiser state encoding.
package nn_pkg;
  localparam int FRAC   = 8;
  localparam int N_OUT  = 8;
  localparam int DATA_W = 16;

  localparam logic [1:0] ACT_LIN  = 2'b00;
  localparam logic [1:0] ACT_RELU = 2'b01;
  localparam logic [1:0] ACT_HSIG = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/nn_act.sv
// Combinational fixed-point activation: linear, ReLU or hard-sigmoid,
// evaluated in 18-bit signed and saturated back to 16 bits.
module nn_act #(
  parameter int FRAC = nn_pkg::FRAC
) (
  input  logic [15:0] z,
  input  logic [1:0]  act_sel,
  output logic [15:0] y
);
  import nn_pkg::*;

  localparam logic signed [17:0] HALF = 18'sd1 <<< (FRAC - 1);
  localparam logic signed [17:0] ONE  = 18'sd1 <<< FRAC;

  logic signed [17:0] zx;
  logic signed [17:0] t;
  logic signed [17:0] r;

  always_comb begin
    zx = {{2{z[15]}}, z};
    // Arithmetic shift floors toward -inf, giving 0.25*z + 0.5.
    t  = (zx >>> 2) + HALF;
    case (act_sel)
      ACT_RELU: r = zx[17] ? 18'sd0 : zx;
      ACT_HSIG: r = (t < 18'sd0) ? 18'sd0 : ((t > ONE) ? ONE : t);
      default:  r = zx;
    endcase
    if (r > 18'sd32767)
      y = 16'h7FFF;
    else if (r < -18'sd32768)
      y = 16'h8000;
    else
      y = r[15:0];
  end
endmodule

// File: rtl/nn_act_ser.sv
// Captures eight accumulator results in one cycle, then streams their
// activated values out one beat per handshake with index and last flag.
module nn_act_ser #(
  parameter int FRAC  = nn_pkg::FRAC,
  parameter int N_OUT = nn_pkg::N_OUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] z0,
  input  logic [15:0] z1,
  input  logic [15:0] z2,
  input  logic [15:0] z3,
  input  logic [15:0] z4,
  input  logic [15:0] z5,
  input  logic [15:0] z6,
  input  logic [15:0] z7,
  input  logic [1:0]  act_sel,
  input  logic        cap_valid,
  output logic        cap_ready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic [2:0]  m_idx,
  output logic        m_last
);
  import nn_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(N_OUT - 1);

  logic [DATA_W-1:0] z_in [N_OUT];
  logic [DATA_W-1:0] zbuf [N_OUT];
  logic [1:0]        act_reg;
  state_t            state;
  logic              capture;
  logic              beat;
  logic [2:0]        nxt_idx;
  logic [DATA_W-1:0] act_z;
  logic [DATA_W-1:0] act_y;
  logic [1:0]        act_mode;

  assign z_in[0] = z0;
  assign z_in[1] = z1;
  assign z_in[2] = z2;
  assign z_in[3] = z3;
  assign z_in[4] = z4;
  assign z_in[5] = z5;
  assign z_in[6] = z6;
  assign z_in[7] = z7;

  assign capture = cap_valid && cap_ready;
  assign beat    = m_valid && m_ready;
  assign nxt_idx = m_idx + 3'd1;

  // Single activation unit: fed live z0 on the capture edge, else the buffer.
  assign act_z    = capture ? z0 : zbuf[nxt_idx];
  assign act_mode = capture ? act_sel : act_reg;

  nn_act #(.FRAC(FRAC)) u_act (
    .z       (act_z),
    .act_sel (act_mode),
    .y       (act_y)
  );

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          zbuf[gi] <= '0;
        else if (capture)
          zbuf[gi] <= z_in[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_ready <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_idx     <= '0;
      m_last    <= 1'b0;
      act_reg   <= ACT_LIN;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            act_reg   <= act_sel;
            m_data    <= act_y;
            m_idx     <= '0;
            m_valid   <= 1'b1;
            m_last    <= 1'b0;
            cap_ready <= 1'b0;
            state     <= SEND;
          end else begin
            cap_ready <= 1'b1;
          end
        end
        SEND: begin
          if (beat) begin
            if (m_idx == LAST_IDX) begin
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              cap_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              m_idx  <= nxt_idx;
              m_data <= act_y;
              m_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nn_act_ser.sv
// Scoreboard bench for nn_act_ser: expected beats are queued at capture and
// checked as the stream drains; directed steps cover the listed scenarios.
module tb_nn_act_ser;
  localparam int FRAC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] zv [8];
  logic [1:0]  act_sel = 2'b00;
  logic        cap_valid = 1'b0;
  logic        cap_ready;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic [2:0]  m_idx;
  logic        m_last;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  i;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int cap_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_act_ser #(.FRAC(FRAC), .N_OUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .z0        (zv[0]),
    .z1        (zv[1]),
    .z2        (zv[2]),
    .z3        (zv[3]),
    .z4        (zv[4]),
    .z5        (zv[5]),
    .z6        (zv[6]),
    .z7        (zv[7]),
    .act_sel   (act_sel),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_idx     (m_idx),
    .m_last    (m_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference activation written from the arithmetic definition.
  function automatic logic [15:0] model(input logic [15:0] z, input logic [1:0] sel);
    int v, fl, t;
    v = $signed(z);
    case (sel)
      2'b01: return (v < 0) ? 16'h0000 : z;
      2'b10: begin
        fl = (v >= 0) ? v / 4 : -((-v + 3) / 4);
        t  = fl + (1 << (FRAC - 1));
        if (t < 0) t = 0;
        else if (t > (1 << FRAC)) t = 1 << FRAC;
        return t[15:0];
      end
      default: return z;
    endcase
  endfunction

  // Beat is sampled on the falling edge; it transfers on the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_beat: observed idx %0d expected no beat", m_idx);
      end else begin
        e = sb.pop_front();
        chk("beat_data", m_data, e.d);
        chk("beat_idx", m_idx, e.i);
        chk("beat_last", m_last, e.l);
        if (m_last) last_hs_cyc <= cyc + 1;
      end
    end
  end

  task automatic capture(input logic [1:0] sel, input bit keep);
    bit ok = 0;
    act_sel   = sel;
    cap_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cap_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("cap_ready_wait", cap_ready, 1);
      cap_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.d = model(zv[k], sel);
      b.i = 3'(k);
      b.l = (k == 7);
      sb.push_back(b);
    end
    cap_cyc = cyc + 1;
    @(posedge clk);
    #1;
    if (!keep) cap_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", sb.size(), 0);
    chk("idle_m_valid", m_valid, 0);
    chk("idle_cap_ready", cap_ready, 1);
    sb.delete();
  endtask

  task automatic rand_z();
    for (int k = 0; k < 8; k++) zv[k] = 16'($urandom);
  endtask

  initial begin
    int cap_a;
    int cap_b;
    bit hit;
    for (int k = 0; k < 8; k++) zv[k] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cap_ready", cap_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_m_last", m_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("release_cap_ready", cap_ready, 0);
    @(posedge clk);
    #1;
    chk("cap_ready_after_reset", cap_ready, 1);

    // Basic linear stream
    for (int k = 0; k < 8; k++) zv[k] = 16'(k + 1);
    capture(2'b00, 0);
    chk("first_beat_valid", m_valid, 1);
    chk("first_beat_idx", m_idx, 0);
    chk("send_cap_ready", cap_ready, 0);
    drain();

    // ReLU
    rand_z();
    zv[0] = 16'hFF00;
    zv[1] = 16'h0180;
    capture(2'b01, 0);
    drain();

    // Hard-sigmoid incl. saturation and negative truncation
    zv[0] = 16'h0100; zv[1] = 16'hFD00; zv[2] = 16'h0400; zv[3] = 16'h0000;
    zv[4] = 16'hFFFF; zv[5] = 16'h7FFF; zv[6] = 16'h8000; zv[7] = 16'h0101;
    capture(2'b10, 0);
    drain();

    // Backpressure at beat 3 with inputs churning
    rand_z();
    capture(2'($urandom_range(0, 3)), 0);
    hit = 0;
    for (int n = 0; n < 20; n++) begin
      if (m_valid && m_idx == 3) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_reach_beat3", hit, 1);
    m_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      rand_z();
      act_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_idx", m_idx, 3);
      if (sb.size() > 0) chk("bp_m_data", m_data, sb[0].d);
      chk("bp_cap_ready", cap_ready, 0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    drain();

    // Back-to-back vectors with cap_valid held; act_sel changes mid-vector
    rand_z();
    capture(2'b00, 1);
    cap_a = cap_cyc;
    rand_z();
    capture(2'b01, 0);
    cap_b = cap_cyc;
    chk("b2b_gap", cap_b - last_hs_cyc, 1);
    drain();
    chk("b2b_total", last_hs_cyc - cap_a, 17);

    // Asynchronous reset during beat 4
    rand_z();
    capture(2'b00, 0);
    hit = 0;
    for (int n = 0; n < 20; n++) begin
      if (m_valid && m_idx == 4) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rst_reach_beat4", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_m_idx", m_idx, 0);
    chk("async_m_data", m_data, 0);
    chk("async_m_last", m_last, 0);
    chk("async_cap_ready", cap_ready, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rerelease_cap_ready", cap_ready, 0);
    @(posedge clk);
    #1;
    chk("rerelease_cap_ready_up", cap_ready, 1);
    rand_z();
    capture(2'b10, 0);
    chk("post_reset_idx", m_idx, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/nn_act_ser.md
Name: nn_act_ser

Overview:
- Output stage directly downstream of the 8-neuron MAC datapath.
- Captures the eight signed 16-bit accumulator results z0..z7 in one cycle, once the controller signals that accumulation is complete.
- Applies a selectable fixed-point activation (linear, ReLU or hard-sigmoid) to each result.
- Serialises the eight activated values onto a valid/ready output stream. Capture releases the MAC datapath so the controller can clear it while results drain.

Parameters:
- FRAC, 8, number of fractional bits in the Q-format shared with the MAC datapath (default Q8.8).
- N_OUT, 8, neurons per vector; fixed at 8 to match the datapath width.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- z0..z7  in  16 each  signed accumulator results from the MAC datapath, Q(15-FRAC).FRAC
- act_sel  in  2  activation: 00 linear, 01 ReLU, 10 hard-sigmoid, 11 linear
- cap_valid  in  1  controller asserts when z0..z7 are final and stable
- cap_ready  out  1  block can capture a new vector
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the beat
- m_data  out  16  signed activated value
- m_idx  out  3  neuron index of the current beat, 0..7
- m_last  out  1  high on the beat with m_idx==7

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE, cap_ready 0, m_valid 0, m_data 0, m_idx 0, m_last 0. Capture buffer and latched act_sel are cleared to 0.
- States: IDLE and SEND.
- IDLE: cap_ready is registered and rises one cycle after reset release.
- Capture: a capture occurs when cap_valid && cap_ready at a clock edge. On that edge:
  - z0..z7 and act_sel are latched into the buffer.
  - m_data <= act(z0), m_idx <= 0, m_valid <= 1, m_last <= 0.
  - cap_ready <= 0 and state <= SEND.
  - Latency from capture edge to the first valid beat is 1 cycle.
- SEND, beat handshake: a beat transfers when m_valid && m_ready.
  - If m_idx < 7: m_idx <= m_idx+1, m_data <= act(buf[m_idx+1]), m_last <= (m_idx+1 == 7).
  - If m_idx == 7: m_valid <= 0, m_last <= 0, cap_ready <= 1, state <= IDLE.
- Backpressure: while m_valid && !m_ready, m_data, m_idx and m_last hold unchanged.
- Throughput: 8 beats per vector. Minimum inter-vector gap is 1 idle cycle; cap_ready is never high in SEND.
- Input stability: z0..z7 and act_sel are ignored outside the capture edge. Changes to act_sel mid-vector have no effect.
- cap_valid while cap_ready is 0: no effect. The controller holds cap_valid until cap_ready.
- Activation arithmetic: computed in 18-bit signed, then saturated to 16-bit.
  - linear: y = z.
  - ReLU: y = (z < 0) ? 0 : z.
  - hard-sigmoid: t = (z >>> 2) + 2^(FRAC-1), then y = clamp(t, 0, 2^FRAC). This is 0.25*z + 0.5 limited to [0, 1.0]. The shift is arithmetic and truncates toward negative infinity.
- Reset mid-vector: every output immediately returns to its reset value and the partial vector is discarded. No beat is replayed after reset.

Decomposition:
- Shared package nn_pkg: FRAC, N_OUT, DATA_W=16, activation codes ACT_LIN=2'b00, ACT_RELU=2'b01, ACT_HSIG=2'b10, state encodings IDLE/SEND.
- One combinational sub-module, nn_act, is natural. Inputs: z[15:0] and act_sel. Output: y[15:0]. It is instantiated once on the buffer read mux.

Test Plan:
- Basic stream: reset, then act_sel=00, z0..z7=0x0001..0x0008, cap_valid=1, m_ready=1.
  - Eight consecutive beats follow, m_data 0x0001..0x0008 with m_idx 0..7.
  - m_last is high only on beat 7.
  - cap_ready returns to 1 the cycle after beat 7.
- ReLU: act_sel=01, z0=0xFF00 (-1.0), z1=0x0180 (1.5).
  - Beat 0 has m_data 0x0000; beat 1 has m_data 0x0180.
- Hard-sigmoid with saturation: act_sel=10.
  - z=0x0100 gives 0x00C0.
  - z=0xFD00 (-3.0) gives 0x0000.
  - z=0x0400 (4.0) gives 0x0100.
  - z=0x0000 gives 0x0080.
- Backpressure: hold m_ready=0 for 5 cycles at beat 3 with random z changes on the inputs.
  - m_data, m_idx=3 and m_valid stay stable throughout.
  - The remaining beats carry the originally captured values.
- Back-to-back vectors with cap_valid held high:
  - The second capture occurs exactly 1 cycle after the first vector's last handshake.
  - The total for two vectors is 17 cycles from the first capture edge to the last beat, with m_ready=1.
- Reset mid-vector: assert rst_n=0 asynchronously during beat 4.
  - m_valid drops to 0 immediately, without waiting for a clock edge.
  - After release, cap_ready=1 after one cycle and the next capture starts at m_idx 0.
